// File: rtl/bytecode_decode.sv
// rtl/bytecode_decode.sv - variable-length bytecode assembler/decoder (optional BYTECODE_DECODE_SIGN_EXT_EN)
module bytecode_decode #(
    parameter int                  INSTR_W   = 8,
    parameter int                  OPC_W     = 4,
    parameter logic [2**OPC_W-1:0] EXT1_MASK = '0,
    parameter logic [2**OPC_W-1:0] EXT2_MASK = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INSTR_W-1:0]           in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [OPC_W-1:0]             opcode,
    output logic [INSTR_W-OPC_W-1:0]     operand,
    output logic [2*INSTR_W-1:0]         imm,
    output logic [1:0]                   len,
    output logic                         out_valid,
    input  logic                         out_ready
);
    localparam int SH_W = INSTR_W - OPC_W;
    localparam int IW2  = 2 * INSTR_W;

    typedef enum logic [1:0] {
        S_OPC   = 2'd0,
        S_B1OF1 = 2'd1,
        S_B1OF2 = 2'd2,
        S_B2OF2 = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [OPC_W-1:0]     asm_opc;
    logic [SH_W-1:0]      asm_sh;
    logic [INSTR_W-1:0]   asm_hi;

    logic                 take;
    logic                 cmp;
    logic [OPC_W-1:0]     cmp_opc;
    logic [SH_W-1:0]      cmp_sh;
    logic [IW2-1:0]       cmp_imm;
    logic [1:0]           cmp_len;

    logic [OPC_W-1:0]     in_opc;
    logic [SH_W-1:0]      in_sh;

    assign in_opc   = in_data[INSTR_W-1:SH_W];
    assign in_sh    = in_data[SH_W-1:0];
    assign in_ready = !flush && (!out_valid || out_ready);
    assign take     = in_valid && in_ready;

    function automatic logic [IW2-1:0] ext_sh(input logic [SH_W-1:0] s);
`ifdef BYTECODE_DECODE_SIGN_EXT_EN
        return {{(IW2-SH_W){s[SH_W-1]}}, s};
`else
        return {{(IW2-SH_W){1'b0}}, s};
`endif
    endfunction

    function automatic logic [IW2-1:0] ext_b(input logic [INSTR_W-1:0] b);
`ifdef BYTECODE_DECODE_SIGN_EXT_EN
        return {{INSTR_W{b[INSTR_W-1]}}, b};
`else
        return {{INSTR_W{1'b0}}, b};
`endif
    endfunction

    always_comb begin
        state_n = state;
        cmp     = 1'b0;
        cmp_opc = asm_opc;
        cmp_sh  = asm_sh;
        cmp_imm = '0;
        cmp_len = 2'd0;
        case (state)
            S_OPC: begin
                if (EXT2_MASK[in_opc]) begin
                    state_n = S_B1OF2;
                end else if (EXT1_MASK[in_opc]) begin
                    state_n = S_B1OF1;
                end else begin
                    // single-byte instruction completes straight from the input byte
                    cmp     = 1'b1;
                    cmp_opc = in_opc;
                    cmp_sh  = in_sh;
                    cmp_imm = ext_sh(in_sh);
                end
            end
            S_B1OF1: begin
                cmp     = 1'b1;
                cmp_imm = ext_b(in_data);
                cmp_len = 2'd1;
                state_n = S_OPC;
            end
            S_B1OF2: begin
                state_n = S_B2OF2;
            end
            S_B2OF2: begin
                cmp     = 1'b1;
                cmp_imm = {asm_hi, in_data};
                cmp_len = 2'd2;
                state_n = S_OPC;
            end
            default: state_n = S_OPC;
        endcase
        if (!take) begin
            state_n = state;
            cmp     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_OPC;
            asm_opc   <= '0;
            asm_sh    <= '0;
            asm_hi    <= '0;
            opcode    <= '0;
            operand   <= '0;
            imm       <= '0;
            len       <= 2'd0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= S_OPC;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (take && state == S_OPC) begin
                asm_opc <= in_opc;
                asm_sh  <= in_sh;
            end
            if (take && state == S_B1OF2) begin
                asm_hi <= in_data;
            end
            // a completion in the same cycle as an output transfer reloads and keeps valid high
            if (cmp) begin
                opcode    <= cmp_opc;
                operand   <= cmp_sh;
                imm       <= cmp_imm;
                len       <= cmp_len;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bytecode_decode.sv
// tb/tb_bytecode_decode.sv - table-driven scoreboard bench for bytecode_decode
module tb_bytecode_decode;
`ifdef BYTECODE_DECODE_SIGN_EXT_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic [15:0] imm;
    logic [1:0]  len;
    logic        out_valid;
    logic        out_ready;

    bytecode_decode #(
        .INSTR_W  (8),
        .OPC_W    (4),
        .EXT1_MASK(16'h0002),
        .EXT2_MASK(16'h0004)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .opcode   (opcode),
        .operand  (operand),
        .imm      (imm),
        .len      (len),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  opr;
        logic [15:0] imm;
        logic [1:0]  len;
    } exp_t;

    typedef struct packed {
        logic [2:0][7:0] b;
        logic [1:0]      n;
        exp_t            e;
    } vec_t;

    exp_t q[$];
    vec_t tbl[9];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [1:0] n, input logic [3:0] opc, input logic [3:0] opr,
                                input logic [15:0] im, input logic [1:0] ln);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.n = n;
        v.e.opc = opc; v.e.opr = opr; v.e.imm = im; v.e.len = ln;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] opc, input logic [3:0] opr, input logic [15:0] im,
                        input logic [1:0] ln);
        exp_t e;
        e.opc = opc; e.opr = opr; e.imm = im; e.len = ln;
        q.push_back(e);
    endtask

    // called at a falling edge; returns at the falling edge after the byte transferred
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #3;
        if (rst && out_valid && out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: opc=%0h opr=%0h imm=%0h len=%0d", opcode, operand, imm, len);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (opcode !== e.opc || operand !== e.opr || imm !== e.imm || len !== e.len) begin
                    bad++;
                    $display("FAIL output: got opc=%0h opr=%0h imm=%0h len=%0d expected opc=%0h opr=%0h imm=%0h len=%0d",
                             opcode, operand, imm, len, e.opc, e.opr, e.imm, e.len);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(8'h3A, 8'h00, 8'h00, 2'd0, 4'h3, 4'hA, SE ? 16'hFFFA : 16'h000A, 2'd0);
        tbl[1] = mk(8'h5C, 8'h00, 8'h00, 2'd0, 4'h5, 4'hC, SE ? 16'hFFFC : 16'h000C, 2'd0);
        tbl[2] = mk(8'h17, 8'hF0, 8'h00, 2'd1, 4'h1, 4'h7, SE ? 16'hFFF0 : 16'h00F0, 2'd1);
        tbl[3] = mk(8'h2B, 8'h12, 8'h34, 2'd2, 4'h2, 4'hB, 16'h1234, 2'd2);
        tbl[4] = mk(8'h15, 8'h7F, 8'h00, 2'd1, 4'h1, 4'h5, 16'h007F, 2'd1);
        tbl[5] = mk(8'h24, 8'hFF, 8'h00, 2'd2, 4'h2, 4'h4, 16'hFF00, 2'd2);
        tbl[6] = mk(8'h07, 8'h00, 8'h00, 2'd0, 4'h0, 4'h7, 16'h0007, 2'd0);
        tbl[7] = mk(8'hF1, 8'h00, 8'h00, 2'd0, 4'hF, 4'h1, 16'h0001, 2'd0);
        tbl[8] = mk(8'h1E, 8'h80, 8'h00, 2'd1, 4'h1, 4'hE, SE ? 16'hFF80 : 16'h0080, 2'd1);

        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'h3A; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_opcode", {28'd0, opcode}, 32'd0);
        chk("reset_operand", {28'd0, operand}, 32'd0);
        chk("reset_imm", {16'd0, imm}, 32'd0);
        chk("reset_len", {30'd0, len}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // full-rate single-byte stream
        push(4'h3, 4'hA, SE ? 16'hFFFA : 16'h000A, 2'd0);
        send(8'h3A);
        chk("rate_valid0", {31'd0, out_valid}, 32'd1);
        chk("rate_opc0", {28'd0, opcode}, 32'h3);
        push(4'h5, 4'hC, SE ? 16'hFFFC : 16'h000C, 2'd0);
        send(8'h5C);
        chk("rate_valid1", {31'd0, out_valid}, 32'd1);
        chk("rate_opc1", {28'd0, opcode}, 32'h5);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            q.push_back(tbl[i].e);
            for (int j = 0; j <= int'(tbl[i].n); j++) send(tbl[i].b[j]);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // backpressure: held output blocks the next opcode byte
        push(4'h1, 4'h7, SE ? 16'hFFF0 : 16'h00F0, 2'd1);
        send(8'h17);
        out_ready = 1'b0;
        send(8'hF0);
        in_data = 8'h2B; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_imm", {16'd0, imm}, SE ? 32'hFFF0 : 32'h00F0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        push(4'h2, 4'hB, 16'h1234, 2'd2);
        send(8'h2B);
        send(8'h12);
        send(8'h34);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // flush mid-instruction
        send(8'h2B);
        send(8'h12);
        flush = 1'b1; in_data = 8'h34; in_valid = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        push(4'h3, 4'hA, SE ? 16'hFFFA : 16'h000A, 2'd0);
        send(8'h3A);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // flush drops a held output
        out_ready = 1'b0;
        send(8'h5C);
        chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_keeps_opc", {28'd0, opcode}, 32'h5);
        out_ready = 1'b1;
        @(negedge clk);

        // reset mid-instruction
        send(8'h2B);
        send(8'h12);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        push(4'h3, 4'hA, SE ? 16'hFFFA : 16'h000A, 2'd0);
        send(8'h3A);
        chk("rst_mid_len", {30'd0, len}, 32'd0);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
